// File: rtl/fused_cnn_pkg.sv
// Shared definitions for the fused 3x3 -> 1x1 CNN pipeline: layer geometry
// defaults used by both the writer-side data controller and the 1x1 IFM reader.
package fused_cnn_pkg;

    localparam int WPP_DEF        = 32;    // 128 channels / 4 bytes per word
    localparam int NUM_GROUPS_DEF = 8;     // 32 filters / 4 PEs
    localparam int NUM_PIXELS_DEF = 3136;  // 56 x 56

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        READ = 2'd2,
        DONE = 2'd3
    } reader_state_t;

endpackage

// File: rtl/buf_occupancy_counter.sv
// Word-occupancy counter for a ring buffer: +1 per committed word, -DEC per
// released block, with a full flag and a sticky overflow for dropped commits.
module buf_occupancy_counter #(
    parameter int DEPTH = 1024,
    parameter int DEC   = 32,
    parameter int OCC_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_ovf,
    input  logic             inc,
    input  logic             dec,
    output logic [OCC_W-1:0] occ,
    output logic [OCC_W-1:0] occ_next,
    output logic             full,
    output logic             overflow
);

    logic inc_ok;

    // occ_next is exported so a consumer can decide on the post-release level
    // (including a same-cycle commit) without waiting a cycle.
    always_comb begin
        full     = (occ == OCC_W'(DEPTH));
        inc_ok   = inc && !full;
        occ_next = occ + OCC_W'(inc_ok) - (dec ? OCC_W'(DEC) : '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ      <= '0;
            overflow <= 1'b0;
        end else begin
            occ <= occ_next;
            if (clr_ovf) begin
                overflow <= 1'b0;
            end else if (inc && full) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv1x1_ifm_reader.sv
// Read-side controller of the 3x3 -> 1x1 pipeline BRAM: replays each committed
// pixel once per filter group, driving BRAM/weight addresses and PE strobes.
module conv1x1_ifm_reader
    import fused_cnn_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int WPP        = WPP_DEF,
    parameter int NUM_GROUPS = NUM_GROUPS_DEF,
    parameter int NUM_PIXELS = NUM_PIXELS_DEF,
    parameter int DEPTH      = 1024,
    parameter int OCC_W      = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              wr_commit,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] w_addr,
    output logic              ifm_valid,
    output logic [3:0]        pe_reset,
    output logic              pass_done,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output reader_state_t     state,
    output logic [OCC_W-1:0]  occupancy,
    output logic              buf_full
);

    localparam int BASE_W = $clog2(DEPTH);
    localparam int BW1    = BASE_W + 1;
    localparam int WORD_W = (WPP > 1) ? $clog2(WPP) : 1;
    localparam int GRP_W  = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam int PIX_W  = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;

    localparam logic [WORD_W-1:0] WORD_LAST  = WORD_W'(WPP - 1);
    localparam logic [GRP_W-1:0]  GROUP_LAST = GRP_W'(NUM_GROUPS - 1);
    localparam logic [PIX_W-1:0]  PIXEL_LAST = PIX_W'(NUM_PIXELS - 1);

    reader_state_t     state_q;
    logic [WORD_W-1:0] word_q;
    logic [GRP_W-1:0]  group_q;
    logic [PIX_W-1:0]  pixel_q;
    logic [BASE_W-1:0] base_q;
    logic [BASE_W-1:0] base_nx;
    logic [BW1-1:0]    base_sum;
    logic [OCC_W-1:0]  occ_next;

    logic addr_valid;
    logic word_last;
    logic group_last;
    logic pixel_last;
    logic release_px;
    logic start_ok;
    logic last_q;
    logic fin_q;
    logic fin_pd;

    always_comb begin
        addr_valid = (state_q == READ);
        word_last  = (word_q == WORD_LAST);
        group_last = (group_q == GROUP_LAST);
        pixel_last = (pixel_q == PIXEL_LAST);
        release_px = addr_valid && word_last && group_last;
        start_ok   = start && (state_q == IDLE) && !busy;
        base_sum   = BW1'(base_q) + BW1'(WPP);
        base_nx    = (base_sum >= BW1'(DEPTH)) ? BASE_W'(base_sum - BW1'(DEPTH))
                                               : BASE_W'(base_sum);
        // base is a multiple of WPP, so base + word never wraps the ring.
        rd_addr    = ADDR_W'(base_q) + ADDR_W'(word_q);
        w_addr     = ADDR_W'(group_q) * ADDR_W'(WPP) + ADDR_W'(word_q);
        state      = state_q;
    end

    buf_occupancy_counter #(
        .DEPTH (DEPTH),
        .DEC   (WPP),
        .OCC_W (OCC_W)
    ) u_occ (
        .clk      (clk),
        .reset    (reset),
        .clr_ovf  (start_ok),
        .inc      (wr_commit),
        .dec      (release_px),
        .occ      (occupancy),
        .occ_next (occ_next),
        .full     (buf_full),
        .overflow (overflow)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            word_q  <= '0;
            group_q <= '0;
            pixel_q <= '0;
            base_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        word_q  <= '0;
                        group_q <= '0;
                        pixel_q <= '0;
                        base_q  <= '0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (occupancy >= OCC_W'(WPP)) begin
                        state_q <= READ;
                    end
                end
                READ: begin
                    if (!word_last) begin
                        word_q <= word_q + WORD_W'(1);
                    end else begin
                        word_q <= '0;
                        if (!group_last) begin
                            group_q <= group_q + GRP_W'(1);
                        end else begin
                            group_q <= '0;
                            base_q  <= base_nx;
                            if (pixel_last) begin
                                pixel_q <= '0;
                                state_q <= DONE;
                            end else begin
                                pixel_q <= pixel_q + PIX_W'(1);
                                if (occ_next < OCC_W'(WPP)) begin
                                    state_q <= WAIT;
                                end
                            end
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Strobe pipeline: address cycle N -> ifm_valid/pe_reset at N+1,
    // pass_done at N+2, and layer done one cycle after the final pass_done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ifm_valid <= 1'b0;
            pe_reset  <= 4'h0;
            last_q    <= 1'b0;
            fin_q     <= 1'b0;
            pass_done <= 1'b0;
            fin_pd    <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            ifm_valid <= addr_valid;
            pe_reset  <= {4{addr_valid && (word_q == '0)}};
            last_q    <= addr_valid && word_last;
            fin_q     <= release_px && pixel_last;
            pass_done <= last_q;
            fin_pd    <= fin_q;
            done      <= pass_done && fin_pd;
            if (start_ok) begin
                busy <= 1'b1;
            end else if (pass_done && fin_pd) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv1x1_ifm_reader.sv
// Bench for conv1x1_ifm_reader with WPP=4, NUM_GROUPS=2, NUM_PIXELS=2, DEPTH=8.
module tb_conv1x1_ifm_reader;
    import fused_cnn_pkg::*;

    localparam int ADDR_W = 32;
    localparam int WPP    = 4;
    localparam int NG     = 2;
    localparam int NP     = 2;
    localparam int DEPTH  = 8;
    localparam int OCC_W  = 4;
    localparam int SB_W   = 16 + ADDR_W + ADDR_W + 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              wr_commit;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] w_addr;
    logic              ifm_valid;
    logic [3:0]        pe_reset;
    logic              pass_done;
    logic              busy;
    logic              done;
    logic              overflow;
    reader_state_t     state;
    logic [OCC_W-1:0]  occupancy;
    logic              buf_full;

    conv1x1_ifm_reader #(
        .ADDR_W     (ADDR_W),
        .WPP        (WPP),
        .NUM_GROUPS (NG),
        .NUM_PIXELS (NP),
        .DEPTH      (DEPTH),
        .OCC_W      (OCC_W)
    ) dut (
        .clk       (clk),
        .reset     (rst),
        .start     (start),
        .wr_commit (wr_commit),
        .rd_addr   (rd_addr),
        .w_addr    (w_addr),
        .ifm_valid (ifm_valid),
        .pe_reset  (pe_reset),
        .pass_done (pass_done),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
        .state     (state),
        .occupancy (occupancy),
        .buf_full  (buf_full)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [SB_W-1:0]   exp_q[$];
    bit                sb_en = 1'b0;
    logic [ADDR_W-1:0] prev_rd = '0;
    logic [ADDR_W-1:0] prev_wa = '0;
    int                prev_commits = 0;
    int                commit_cnt = 0;
    int                done_cnt = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected stream for one layer: linear end-of-pixel word, rd_addr, w_addr, pe_reset.
    task automatic push_layer();
        for (int p = 0; p < NP; p++)
            for (int g = 0; g < NG; g++)
                for (int w = 0; w < WPP; w++) begin
                    logic [15:0]       lin_end;
                    logic [ADDR_W-1:0] rd;
                    logic [ADDR_W-1:0] wa;
                    logic [3:0]        pe;
                    lin_end = 16'((p + 1) * WPP);
                    rd      = ADDR_W'(((p * WPP) % DEPTH) + w);
                    wa      = ADDR_W'(g * WPP + w);
                    pe      = (w == 0) ? 4'hF : 4'h0;
                    exp_q.push_back({lin_end, rd, wa, pe});
                end
    endtask

    // Called at the negedge: data seen with ifm_valid belongs to last cycle's address.
    task automatic sb_sample();
        logic [SB_W-1:0] e;
        if (done) done_cnt++;
        if (sb_en && ifm_valid) begin
            if (exp_q.size() == 0) begin
                check("sb_extra_valid", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("sb_addr_pe", {prev_rd, prev_wa, pe_reset}, e[67:0]);
                check("sb_no_read_ahead", (int'(e[SB_W-1 -: 16]) <= prev_commits), 1'b1);
            end
        end
        prev_rd      = rd_addr;
        prev_wa      = w_addr;
        prev_commits = commit_cnt;
    endtask

    // One cycle: apply inputs after the edge, then observe at the negedge.
    task automatic step(input logic s, input logic c);
        @(posedge clk);
        if (wr_commit && !rst) commit_cnt++;
        #1;
        start     = s;
        wr_commit = c;
        @(negedge clk);
        sb_sample();
    endtask

    task automatic preload(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1);
    endtask

    typedef struct {
        logic       start;
        logic [7:0] exp;  // {ifm_valid, pe_reset, pass_done, done, busy}
    } vec_t;

    vec_t tbl[22];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int vcnt;
        int first_v;
        int last_v;
        bit got_done;

        for (int k = 0; k < 22; k++) begin
            tbl[k].start  = (k == 0) || (k == 10);
            tbl[k].exp[7] = (k >= 3) && (k <= 18);
            tbl[k].exp[6:3] = (k == 3 || k == 7 || k == 11 || k == 15) ? 4'hF : 4'h0;
            tbl[k].exp[2] = (k == 7 || k == 11 || k == 15 || k == 19);
            tbl[k].exp[1] = (k == 20);
            tbl[k].exp[0] = (k >= 1) && (k <= 19);
        end

        rst = 1'b1; start = 1'b0; wr_commit = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_addrs", {rd_addr, w_addr}, '0);
        check("reset_strobes", {ifm_valid, pe_reset, pass_done, busy, done, overflow}, '0);
        check("reset_state", state, IDLE);
        check("reset_occ", occupancy, '0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Full layer from 8 preloaded words; a second start mid-layer is ignored.
        commit_cnt = 0;
        preload(8);
        push_layer();
        sb_en = 1'b1;
        d0 = done_cnt;
        for (int k = 0; k < 22; k++) begin
            step(tbl[k].start, 1'b0);
            check($sformatf("tbl_row%0d", k),
                  {ifm_valid, pe_reset, pass_done, done, busy}, tbl[k].exp);
        end
        check("tbl_single_done", done_cnt - d0, 1);
        check("tbl_sb_drained", exp_q.size(), 0);

        // Overflow: commit while the buffer holds DEPTH words.
        commit_cnt = 0;
        preload(8);
        push_layer();
        d0 = done_cnt;
        for (int r = 0; r < 25; r++) begin
            step(r == 0, r == 3);
            if (r == 2) check("ovf_before", overflow, 1'b0);
            if (r == 4) begin
                check("ovf_set", overflow, 1'b1);
                check("ovf_occ_held", occupancy, 4'd8);
                check("ovf_full", buf_full, 1'b1);
            end
        end
        check("ovf_single_done", done_cnt - d0, 1);
        check("ovf_sticky", overflow, 1'b1);
        check("ovf_occ_end", occupancy, 4'd0);
        check("ovf_sb_drained", exp_q.size(), 0);

        // Release coincides with a commit at occupancy 7: no bubble.
        commit_cnt = 0;
        preload(7);
        push_layer();
        d0 = done_cnt; vcnt = 0; first_v = -1; last_v = -1;
        for (int r = 0; r < 24; r++) begin
            step(r == 0, r == 9);
            if (r == 1) check("start_clears_ovf", overflow, 1'b0);
            if (r == 10) begin
                check("same_cycle_occ", occupancy, 4'd4);
                check("same_cycle_state", state, READ);
            end
            if (ifm_valid) begin
                vcnt++;
                if (first_v < 0) first_v = r;
                last_v = r;
            end
        end
        check("same_cycle_valid_cnt", vcnt, 16);
        check("same_cycle_contiguous", last_v - first_v, 15);
        check("same_cycle_done", done_cnt - d0, 1);
        check("same_cycle_sb_drained", exp_q.size(), 0);

        // Trickle: one commit every 3 cycles.
        commit_cnt = 0;
        push_layer();
        d0 = done_cnt; first_v = -1; got_done = 1'b0;
        for (int r = 0; r < 120 && !got_done; r++) begin
            step(r == 0, (r >= 1) && (r <= 22) && ((r - 1) % 3 == 0));
            if (ifm_valid && first_v < 0) first_v = r;
            if (done) got_done = 1'b1;
        end
        check("trickle_done_seen", got_done, 1'b1);
        check("trickle_first_valid", first_v, 13);
        check("trickle_single_done", done_cnt - d0, 1);
        check("trickle_sb_drained", exp_q.size(), 0);

        // Reset mid-READ at pixel 1, group 1, word 0.
        commit_cnt = 0;
        preload(8);
        push_layer();
        for (int r = 0; r <= 14; r++) step(r == 0, 1'b0);
        check("pre_reset_addr", {rd_addr, w_addr}, {32'd4, 32'd4});
        sb_en = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_addrs", {rd_addr, w_addr}, '0);
        check("midrst_strobes", {ifm_valid, pe_reset, pass_done, busy, done, overflow}, '0);
        check("midrst_state", state, IDLE);
        check("midrst_occ", occupancy, '0);
        exp_q.delete();
        d0 = done_cnt;
        step(1'b0, 1'b0);
        rst = 1'b0;
        for (int r = 0; r < 8; r++) step(1'b0, 1'b0);
        check("midrst_no_done", done_cnt - d0, 0);
        check("midrst_idle", state, IDLE);

        // Replay after reset starts again from base 0.
        commit_cnt = 0;
        sb_en = 1'b1;
        preload(8);
        push_layer();
        got_done = 1'b0;
        for (int r = 0; r < 40 && !got_done; r++) begin
            step(r == 0, 1'b0);
            if (done) got_done = 1'b1;
        end
        check("replay_done_seen", got_done, 1'b1);
        check("replay_sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
